// File: rtl/pc_gen_if.sv
// AXI-Stream channel carrying a single XLEN-wide PC beat.
interface axis_if #(
    parameter int unsigned XLEN = 32
);
    logic            tvalid;
    logic            tready;
    logic [XLEN-1:0] tdata;

    modport m (output tvalid, output tdata, input  tready);
    modport s (input  tvalid, input  tdata, output tready);
endinterface

// File: rtl/pc_gen.sv
// Next-fetch-PC generator: sequential PC unless a trap/branch redirect is pending,
// plus the IF/ID invalidate flush for wrong-path instructions.
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INST_BYTES   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    axis_if.m               next_pc_axis_if,
    axis_if.s               current_pc_axis_if,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    output logic            invalidate
);

    logic            run_q, run_d;
    logic            pend_valid_q, pend_valid_d;
    logic            pend_trap_q, pend_trap_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            flush_q, flush_d;
    logic            hs;
    logic            cap_redirect;
    logic [XLEN-1:0] align_mask;

    assign align_mask = {{(XLEN-2){1'b1}}, 2'b00};

    assign current_pc_axis_if.tready = 1'b1;

    assign next_pc_axis_if.tvalid = run_q && current_pc_axis_if.tvalid;
    assign next_pc_axis_if.tdata  = pend_valid_q ? pend_pc_q
                                                 : current_pc_axis_if.tdata + XLEN'(INST_BYTES);

    assign hs = next_pc_axis_if.tvalid && next_pc_axis_if.tready;

    // An undelivered trap is protected from redirects; once it hands off this cycle it may be replaced.
    assign cap_redirect = redirect_valid && !(pend_valid_q && pend_trap_q && !hs);

    always_comb begin
        run_d        = 1'b1;
        pend_valid_d = pend_valid_q;
        pend_trap_d  = pend_trap_q;
        pend_pc_d    = pend_pc_q;
        flush_d      = hs && pend_valid_q;
        if (trap_valid) begin
            pend_valid_d = 1'b1;
            pend_trap_d  = 1'b1;
            pend_pc_d    = trap_pc & align_mask;
        end else if (cap_redirect) begin
            pend_valid_d = 1'b1;
            pend_trap_d  = 1'b0;
            pend_pc_d    = redirect_pc & align_mask;
        end else if (hs && pend_valid_q) begin
            pend_valid_d = 1'b0;
            pend_trap_d  = 1'b0;
        end
    end

    assign invalidate = trap_valid || redirect_valid || flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_trap_q  <= 1'b0;
            pend_pc_q    <= '0;
            flush_q      <= 1'b0;
        end else begin
            run_q        <= run_d;
            pend_valid_q <= pend_valid_d;
            pend_trap_q  <= pend_trap_d;
            pend_pc_q    <= pend_pc_d;
            flush_q      <= flush_d;
        end
    end

    // The fetch unit must come out of reset holding the same vector this block assumes.
    a_reset_vector: assert property (@(posedge clk)
        (rst_n && !run_q && current_pc_axis_if.tvalid) |-> (current_pc_axis_if.tdata == RESET_VECTOR));

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with a scoreboard of expected handshake PCs.
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        rv, tv;
    logic [31:0] rpc, tpc;
    logic        inv;

    int unsigned checks;
    int unsigned errors;
    logic [31:0] sbq[$];

    axis_if #(.XLEN(32)) next_if ();
    axis_if #(.XLEN(32)) cur_if ();

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .INST_BYTES(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .next_pc_axis_if    (next_if),
        .current_pc_axis_if (cur_if),
        .redirect_valid     (rv),
        .redirect_pc        (rpc),
        .trap_valid         (tv),
        .trap_pc            (tpc),
        .invalidate         (inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge; every handshake must consume one scoreboard entry.
    task automatic at_neg();
        logic [31:0] e;
        @(negedge clk);
        if (next_if.tvalid === 1'b1 && next_if.tready === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_hs", next_if.tdata, 32'hxxxx_xxxx);
            end else begin
                e = sbq.pop_front();
                chk("hs_data", next_if.tdata, e);
            end
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        rv = 1'b0; rpc = '0;
        tv = 1'b0; tpc = '0;
        cur_if.tvalid = 1'b1;
        cur_if.tdata  = 32'h0;
        next_if.tready = 1'b1;

        #2;
        chk("reset_tvalid", 32'(next_if.tvalid), 32'h0);
        chk("reset_inv", 32'(inv), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_release_tvalid", 32'(next_if.tvalid), 32'h0);
        to_pos();

        // Sequential fetch
        sbq.push_back(32'h4);
        at_neg();
        chk("seq_tvalid", 32'(next_if.tvalid), 32'h1);
        chk("seq_inv", 32'(inv), 32'h0);
        to_pos();
        cur_if.tdata = 32'h4;
        sbq.push_back(32'h8);
        at_neg();
        chk("seq_data2", next_if.tdata, 32'h8);
        to_pos();

        // Redirect under backpressure, misaligned target
        next_if.tready = 1'b0;
        cur_if.tdata = 32'h100;
        rv = 1'b1; rpc = 32'h1003;
        at_neg();
        chk("redir_inv_same", 32'(inv), 32'h1);
        chk("redir_data_before", next_if.tdata, 32'h104);
        to_pos();
        rv = 1'b0;
        at_neg();
        chk("redir_data_after", next_if.tdata, 32'h1000);
        chk("redir_tvalid_wait", 32'(next_if.tvalid), 32'h1);
        chk("redir_inv_wait", 32'(inv), 32'h0);
        to_pos();
        next_if.tready = 1'b1;
        sbq.push_back(32'h1000);
        at_neg();
        to_pos();
        next_if.tready = 1'b0;
        cur_if.tdata = 32'h1000;
        at_neg();
        chk("redir_flush", 32'(inv), 32'h1);
        chk("redir_seq_resume", next_if.tdata, 32'h1004);
        to_pos();
        at_neg();
        chk("redir_flush_end", 32'(inv), 32'h0);
        to_pos();

        // Trap priority over simultaneous and later redirects
        tv = 1'b1; tpc = 32'h8000_0002;
        rv = 1'b1; rpc = 32'h2000;
        at_neg();
        chk("trap_inv", 32'(inv), 32'h1);
        to_pos();
        tv = 1'b0; rv = 1'b0;
        at_neg();
        chk("trap_pend", next_if.tdata, 32'h8000_0000);
        to_pos();
        rv = 1'b1; rpc = 32'h3000;
        at_neg();
        chk("trap_late_redir_inv", 32'(inv), 32'h1);
        to_pos();
        rv = 1'b0;
        at_neg();
        chk("trap_kept", next_if.tdata, 32'h8000_0000);
        to_pos();
        next_if.tready = 1'b1;
        sbq.push_back(32'h8000_0000);
        at_neg();
        to_pos();
        next_if.tready = 1'b0;
        cur_if.tdata = 32'h8000_0000;
        at_neg();
        chk("trap_flush", 32'(inv), 32'h1);
        chk("trap_seq_resume", next_if.tdata, 32'h8000_0004);
        to_pos();

        // Delivery of 0x100 coincides with new redirect 0x200
        cur_if.tdata = 32'h50;
        rv = 1'b1; rpc = 32'h100;
        at_neg();
        to_pos();
        rv = 1'b0;
        at_neg();
        chk("simul_pend1", next_if.tdata, 32'h100);
        to_pos();
        next_if.tready = 1'b1;
        rv = 1'b1; rpc = 32'h200;
        sbq.push_back(32'h100);
        at_neg();
        chk("simul_inv_hs", 32'(inv), 32'h1);
        to_pos();
        rv = 1'b0;
        next_if.tready = 1'b0;
        cur_if.tdata = 32'h100;
        at_neg();
        chk("simul_pend2", next_if.tdata, 32'h200);
        chk("simul_inv_next", 32'(inv), 32'h1);
        to_pos();
        next_if.tready = 1'b1;
        sbq.push_back(32'h200);
        at_neg();
        to_pos();
        next_if.tready = 1'b0;
        cur_if.tdata = 32'h200;
        at_neg();
        chk("simul_flush2", 32'(inv), 32'h1);
        to_pos();
        at_neg();
        chk("simul_idle_inv", 32'(inv), 32'h0);
        chk("simul_seq", next_if.tdata, 32'h204);
        to_pos();

        // Wrap-around and current tvalid gating
        cur_if.tdata = 32'hFFFF_FFFC;
        next_if.tready = 1'b1;
        sbq.push_back(32'h0);
        at_neg();
        chk("wrap_data", next_if.tdata, 32'h0);
        to_pos();
        cur_if.tvalid = 1'b0;
        at_neg();
        chk("cur_invalid_gates", 32'(next_if.tvalid), 32'h0);
        to_pos();
        cur_if.tvalid = 1'b1;

        // Reset with a redirect pending
        next_if.tready = 1'b0;
        cur_if.tdata = 32'h10;
        rv = 1'b1; rpc = 32'h3000;
        at_neg();
        to_pos();
        rv = 1'b0;
        at_neg();
        chk("rst_pend", next_if.tdata, 32'h3000);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_tvalid", 32'(next_if.tvalid), 32'h0);
        chk("rst_inv", 32'(inv), 32'h0);
        cur_if.tdata = 32'h0;
        to_pos();
        to_pos();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_tvalid", 32'(next_if.tvalid), 32'h0);
        to_pos();
        next_if.tready = 1'b1;
        sbq.push_back(32'h4);
        at_neg();
        chk("rst_first_inv", 32'(inv), 32'h0);
        to_pos();
        next_if.tready = 1'b0;

        chk("sb_drained", 32'(sbq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
